acc_bias_collector: RTL and testbench
=====================================

# acc_bias_collector

Producer side of the activation path. Accepts one row of systolic-array partial sums per handshake and accumulates them over a programmable number of K-tiles into a COLS×COLS buffer. It adds a per-column bias and presents the full matrix as a packed, saturated AB_BW-bit vector with a valid/ready handshake. `o_acc_bias` and `o_bound_en` feed the bound/ReLU stage's `i_acc_bias` and `bound_en` inputs directly.

## Interface
- `COLS`, 5, array dimension (rows = columns = COLS)
- `PS_BW`, 18, signed partial-sum width per element
- `BIAS_BW`, 16, signed bias width per column
- `AB_BW`, 25, signed accumulator/output width per element

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_start`  in  1  start a new matrix; honoured only in IDLE
- `i_num_tiles`  in  8  K-tiles to accumulate, latched at start; 0 is treated as 1
- `i_bias`  in  BIAS_BW*COLS  per-column bias, latched at start; column c at `[(c+1)*BIAS_BW-1 -: BIAS_BW]`
- `i_ps_valid`  in  1  partial-sum row valid
- `o_ps_ready`  out  1  row accepted when valid & ready
- `i_ps_data`  in  PS_BW*COLS  one row; column c at `[(c+1)*PS_BW-1 -: PS_BW]`
- `o_acc_bias`  out  AB_BW*COLS*COLS  result; element (r,c) at `[(r*COLS+c+1)*AB_BW-1 -: AB_BW]`
- `o_acc_valid`  out  1  result valid
- `i_acc_ready`  in  1  downstream accepts result
- `o_bound_en`  out  1  equals `o_acc_valid`; drives the bound stage enable
- `o_busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCUM, BIAS, OUT.
- IDLE
  - `o_ps_ready`=0.
  - On `i_start`: latch tiles (0→1) and bias, zero `row_cnt` and `tile_cnt`, go to ACCUM.
- ACCUM
  - `o_ps_ready`=1.
  - Each handshake updates row `row_cnt`: acc[r][c] = sat(acc[r][c] + sext(ps[c])) when `tile_cnt`>0, otherwise acc[r][c] = sext(ps[c]). No clear pass is needed.
  - `row_cnt` wraps COLS-1→0 and increments `tile_cnt` on wrap.
  - The handshake for row COLS-1 of the last tile moves the FSM to BIAS.
  - Cycles with `i_ps_valid`=0 change nothing.
- BIAS
  - One cycle: acc[r][c] = sat(acc[r][c] + sext(bias[c])) for all r,c. Go to OUT.
- OUT
  - `o_acc_valid`=1; `o_acc_bias` is driven from the accumulator registers and held stable.
  - On `i_acc_ready`: go to IDLE.
- Arithmetic
  - Two's complement throughout.
  - Every add is done at AB_BW+1 bits, then saturated to [-2^(AB_BW-1), 2^(AB_BW-1)-1].
  - Saturation is sticky only through the arithmetic; no wrap-around ever occurs.
- Input handling outside the accepting states
  - `i_start` is ignored in ACCUM, BIAS and OUT.
  - `i_ps_valid` is ignored outside ACCUM.
  - `i_num_tiles` and `i_bias` are sampled only at start.
- Reset
  - Asserting `rst_n` low at any time, including mid-matrix, forces IDLE and clears counters and all accumulators.
  - All outputs are 0 during reset.

## Timing
- Reset values: `o_ps_ready`=0, `o_acc_valid`=0, `o_bound_en`=0, `o_busy`=0, `o_acc_bias`=0.
- `i_start` sampled at cycle T0: `o_busy` and `o_ps_ready` go high at T0+1.
- Full-rate input: one row per cycle, so the minimum ACCUM length is COLS×tiles cycles.
- Last row handshake at cycle T:
  - BIAS at T+1.
  - `o_acc_valid`/`o_bound_en` high from T+2.
- Result accepted at cycle U (`o_acc_valid` & `i_acc_ready`):
  - IDLE at U+1.
  - `o_acc_valid` low at U+1.
  - The earliest new start is sampled at U+1.
- Holding `i_acc_ready` low stalls indefinitely in OUT with data stable.
- Outputs are registered with no combinational path from inputs, except `o_ps_ready`, which is state-decoded only.

## Test plan
- Single tile, bias 16 on every column, ps[r][c]=r*5+c, tiles=1 → element (r,c)=r*5+c+16 (e.g. (4,4)=40); `o_acc_valid` exactly 2 cycles after the 5th row.
- Three tiles, every ps=-100, bias=-5 on every column → every element = -305 (0x1FFFECF).
- Saturation, tiles=255:
  - ps=131071 → every element = 16777215.
  - ps=-131072 → every element = -16777216.
- Back-pressure: hold `i_acc_ready`=0 for 10 cycles in OUT and pulse `i_start` → valid and data stable, `o_ps_ready`=0, start ignored; accept on cycle 11 → IDLE on the next cycle.
- Bubbles: single tile, bias 0, ps=7, random idle cycles inserted between rows → every element = 7; row count is unaffected by bubbles.
- Reset mid-op: assert `rst_n` low after row 2 of tile 0 → all outputs 0; a fresh run with tiles=0 (treated as 1), ps=1, bias 0 → every element = 1.

Source files
------------

// File: rtl/acc_bias_collector_if.sv
// Handshake bundle for acc_bias_collector: partial-sum row stream in,
// biased accumulator matrix out.
interface acc_bias_collector_if #(
  parameter int COLS  = 5,
  parameter int PS_BW = 18,
  parameter int AB_BW = 25
);
  logic                        i_ps_valid;
  logic                        o_ps_ready;
  logic [PS_BW*COLS-1:0]       i_ps_data;
  logic [AB_BW*COLS*COLS-1:0]  o_acc_bias;
  logic                        o_acc_valid;
  logic                        i_acc_ready;
  logic                        o_bound_en;

  // collector side
  modport slave (
    input  i_ps_valid, i_ps_data, i_acc_ready,
    output o_ps_ready, o_acc_bias, o_acc_valid, o_bound_en
  );

  // environment side: row producer and result consumer
  modport master (
    output i_ps_valid, i_ps_data, i_acc_ready,
    input  o_ps_ready, o_acc_bias, o_acc_valid, o_bound_en
  );
endinterface

// File: rtl/acc_bias_collector.sv
// Accumulates COLS-wide partial-sum rows over K-tiles into a COLSxCOLS matrix,
// adds a per-column bias with saturation and hands the matrix downstream.
module acc_bias_collector #(
  parameter int COLS    = 5,
  parameter int PS_BW   = 18,
  parameter int BIAS_BW = 16,
  parameter int AB_BW   = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [7:0]              i_num_tiles,
  input  logic [BIAS_BW*COLS-1:0] i_bias,
  output logic                    o_busy,
  acc_bias_collector_if.slave     bus
);

  localparam int ROW_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

  state_t                     state, state_nxt;
  logic [ROW_W-1:0]           row_cnt;
  logic [7:0]                 tile_cnt;
  logic [7:0]                 tiles;
  logic signed [BIAS_BW-1:0]  bias [COLS];
  logic signed [AB_BW-1:0]    acc  [COLS][COLS];
  logic                       ps_fire;
  logic                       last_row;
  logic                       start_fire;

  function automatic logic signed [AB_BW-1:0] sat_add(
    input logic signed [AB_BW-1:0] a,
    input logic signed [AB_BW-1:0] b
  );
    logic signed [AB_BW:0] sum;
    sum = {a[AB_BW-1], a} + {b[AB_BW-1], b};
    if (sum[AB_BW] != sum[AB_BW-1])
      return sum[AB_BW] ? {1'b1, {(AB_BW-1){1'b0}}} : {1'b0, {(AB_BW-1){1'b1}}};
    return sum[AB_BW-1:0];
  endfunction

  function automatic logic signed [AB_BW-1:0] sext_ps(input logic signed [PS_BW-1:0] v);
    return {{(AB_BW-PS_BW){v[PS_BW-1]}}, v};
  endfunction

  function automatic logic signed [AB_BW-1:0] sext_bias(input logic signed [BIAS_BW-1:0] v);
    return {{(AB_BW-BIAS_BW){v[BIAS_BW-1]}}, v};
  endfunction

  assign start_fire     = (state == IDLE) && i_start;
  assign bus.o_ps_ready = (state == ACCUM);
  assign ps_fire        = bus.i_ps_valid && (state == ACCUM);
  assign last_row       = (row_cnt == ROW_W'(COLS-1)) && (tile_cnt == tiles - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = ACCUM;
      ACCUM:   if (ps_fire && last_row) state_nxt = BIAS;
      BIAS:    state_nxt = OUT;
      OUT:     if (bus.i_acc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      tile_cnt <= '0;
      tiles    <= 8'd1;
    end else if (start_fire) begin
      row_cnt  <= '0;
      tile_cnt <= '0;
      tiles    <= (i_num_tiles == 8'd0) ? 8'd1 : i_num_tiles;
    end else if (ps_fire) begin
      if (row_cnt == ROW_W'(COLS-1)) begin
        row_cnt  <= '0;
        tile_cnt <= tile_cnt + 8'd1;
      end else begin
        row_cnt  <= row_cnt + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_fire)
      for (int c = 0; c < COLS; c++)
        bias[c] <= i_bias[(c+1)*BIAS_BW-1 -: BIAS_BW];
  end

  // first tile overwrites the row, so stale data from the previous matrix never leaks in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < COLS; r++)
        for (int c = 0; c < COLS; c++)
          acc[r][c] <= '0;
    end else if (ps_fire) begin
      for (int c = 0; c < COLS; c++)
        acc[row_cnt][c] <= (tile_cnt == 8'd0)
          ? sext_ps(bus.i_ps_data[(c+1)*PS_BW-1 -: PS_BW])
          : sat_add(acc[row_cnt][c], sext_ps(bus.i_ps_data[(c+1)*PS_BW-1 -: PS_BW]));
    end else if (state == BIAS) begin
      for (int r = 0; r < COLS; r++)
        for (int c = 0; c < COLS; c++)
          acc[r][c] <= sat_add(acc[r][c], sext_bias(bias[c]));
    end
  end

  for (genvar r = 0; r < COLS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign bus.o_acc_bias[(r*COLS+c+1)*AB_BW-1 -: AB_BW] = acc[r][c];
    end
  end

  assign bus.o_acc_valid = (state == OUT);
  assign bus.o_bound_en  = (state == OUT);
  assign o_busy          = (state != IDLE);

endmodule

// File: tb/tb_acc_bias_collector.sv
// Scoreboard bench for acc_bias_collector: each driven matrix pushes its
// expected result, which is popped and compared when the DUT raises valid.
module tb_acc_bias_collector;
  localparam int COLS = 5, PS_BW = 18, BIAS_BW = 16, AB_BW = 25;
  localparam int MW = AB_BW*COLS*COLS;
  localparam longint SMAX = (longint'(1) << (AB_BW-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (AB_BW-1));

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [7:0]              num_tiles = '0;
  logic [BIAS_BW*COLS-1:0] bias = '0;
  logic                    busy;

  acc_bias_collector_if #(.COLS(COLS), .PS_BW(PS_BW), .AB_BW(AB_BW)) bus();

  acc_bias_collector #(.COLS(COLS), .PS_BW(PS_BW), .BIAS_BW(BIAS_BW), .AB_BW(AB_BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .i_num_tiles(num_tiles),
    .i_bias     (bias),
    .o_busy     (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] last_out;
  longint model [COLS][COLS];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic longint el_of(input logic [MW-1:0] vec, input int r, input int c);
    logic signed [AB_BW-1:0] t;
    t = vec[(r*COLS+c+1)*AB_BW-1 -: AB_BW];
    return longint'(t);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_matrix(input int tiles, input int bval, input int mode,
                            input int pconst, input bit bubbles);
    int eff;
    longint v;
    logic [MW-1:0] e;
    eff = (tiles == 0) ? 1 : tiles;
    num_tiles = 8'(tiles);
    for (int c = 0; c < COLS; c++) bias[c*BIAS_BW +: BIAS_BW] = BIAS_BW'(bval);
    start = 1'b1;
    tick;
    start = 1'b0;
    // scramble the start-time inputs: they must already be latched
    num_tiles = 8'($urandom);
    for (int c = 0; c < COLS; c++) bias[c*BIAS_BW +: BIAS_BW] = BIAS_BW'($urandom);
    check("start_busy", longint'(busy), 1);
    check("start_ps_ready", longint'(bus.o_ps_ready), 1);
    for (int t = 0; t < eff; t++) begin
      for (int r = 0; r < COLS; r++) begin
        if (bubbles) begin
          repeat ($urandom_range(0, 3)) begin
            bus.i_ps_valid = 1'b0;
            for (int c = 0; c < COLS; c++) bus.i_ps_data[c*PS_BW +: PS_BW] = PS_BW'($urandom);
            tick;
          end
        end
        for (int c = 0; c < COLS; c++) begin
          v = (mode == 0) ? longint'(r*COLS + c) : longint'(pconst);
          bus.i_ps_data[c*PS_BW +: PS_BW] = PS_BW'(v);
          model[r][c] = (t == 0) ? v : sat(model[r][c] + v);
        end
        bus.i_ps_valid = 1'b1;
        tick;
      end
    end
    bus.i_ps_valid = 1'b0;
    for (int r = 0; r < COLS; r++)
      for (int c = 0; c < COLS; c++) begin
        model[r][c] = sat(model[r][c] + longint'(bval));
        e[(r*COLS+c)*AB_BW +: AB_BW] = AB_BW'(model[r][c]);
      end
    exp_q.push_back(e);
  endtask

  task automatic collect(input int exp_lat, input int hold);
    int lat;
    logic [MW-1:0] e;
    lat = 1;
    while (!bus.o_acc_valid && lat < 50) begin
      tick;
      lat++;
    end
    check("acc_valid_seen", longint'(bus.o_acc_valid), 1);
    if (exp_lat > 0) check("valid_latency", longint'(lat), longint'(exp_lat));
    check("bound_en_high", longint'(bus.o_bound_en), 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int r = 0; r < COLS; r++)
      for (int c = 0; c < COLS; c++)
        check($sformatf("elem_%0d_%0d", r, c), el_of(bus.o_acc_bias, r, c), el_of(e, r, c));
    last_out = bus.o_acc_bias;
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      tick;
      check("hold_valid", longint'(bus.o_acc_valid), 1);
      check("hold_ps_ready", longint'(bus.o_ps_ready), 0);
      check("hold_busy", longint'(busy), 1);
      check("hold_data_00", el_of(bus.o_acc_bias, 0, 0), el_of(e, 0, 0));
      check("hold_data_44", el_of(bus.o_acc_bias, COLS-1, COLS-1), el_of(e, COLS-1, COLS-1));
    end
    start = 1'b0;
    bus.i_acc_ready = 1'b1;
    tick;
    bus.i_acc_ready = 1'b0;
    check("after_accept_valid", longint'(bus.o_acc_valid), 0);
    check("after_accept_bound_en", longint'(bus.o_bound_en), 0);
    check("after_accept_busy", longint'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_ps_ready"}, longint'(bus.o_ps_ready), 0);
    check({tag, "_valid"}, longint'(bus.o_acc_valid), 0);
    check({tag, "_bound_en"}, longint'(bus.o_bound_en), 0);
    check({tag, "_acc_nonzero"}, longint'(|bus.o_acc_bias), 0);
  endtask

  initial begin
    bus.i_ps_valid  = 1'b0;
    bus.i_ps_data   = '0;
    bus.i_acc_ready = 1'b0;
    tick;
    tick;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // single tile, bias 16, ps = r*5+c
    run_matrix(1, 16, 0, 0, 1'b0);
    collect(2, 0);
    check("t1_elem44_const", el_of(last_out, 4, 4), 40);
    check("t1_elem00_const", el_of(last_out, 0, 0), 16);

    // three tiles of -100 with bias -5
    run_matrix(3, -5, 1, -100, 1'b0);
    collect(0, 0);
    check("t2_elem23_const", el_of(last_out, 2, 3), -305);
    check("t2_raw_bits", longint'(last_out[AB_BW-1:0]), 64'h1FFFECF);

    // positive and negative saturation over 255 tiles
    run_matrix(255, 0, 1, 131071, 1'b0);
    collect(0, 0);
    check("sat_pos_const", el_of(last_out, 3, 1), 16777215);
    run_matrix(255, 0, 1, -131072, 1'b0);
    collect(0, 0);
    check("sat_neg_const", el_of(last_out, 1, 3), -16777216);

    // back-pressure: 10 stalled cycles with start pulsed, accept on the 11th
    run_matrix(1, 3, 0, 0, 1'b0);
    collect(0, 10);

    // bubbles between rows
    run_matrix(1, 0, 1, 7, 1'b1);
    collect(0, 0);
    check("bubble_const", el_of(last_out, 4, 0), 7);

    // reset in the middle of tile 0, then a fresh run with tiles=0
    num_tiles = 8'd1;
    bias = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < COLS; c++) bus.i_ps_data[c*PS_BW +: PS_BW] = PS_BW'(100 + r);
      bus.i_ps_valid = 1'b1;
      tick;
    end
    bus.i_ps_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check_all_zero("midreset");
    tick;
    rst_n = 1'b1;
    tick;
    check_all_zero("post_reset");
    run_matrix(0, 0, 1, 1, 1'b0);
    collect(0, 0);
    check("tiles0_const", el_of(last_out, 2, 2), 1);
    check("scoreboard_drained", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
